// File: rtl/prime_collector_if.sv
// Handshake bundle between the prime checker stream, the prime_collector FIFO
// and the downstream reader of buffered primes.
interface prime_collector_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_number;
    logic              in_prime;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_number;

    modport master (
        output in_valid, in_number, in_prime, out_ready,
        input  out_valid, out_number
    );

    modport slave (
        input  in_valid, in_number, in_prime, out_ready,
        output out_valid, out_number
    );
endinterface

// File: rtl/prime_collector.sv
// Buffers prime results from the checker stream in a show-ahead FIFO and keeps
// saturating candidate / prime / drop statistics.
module prime_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    prime_collector_if.slave         bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         cand_count,
    output logic [CNT_W-1:0]         prime_count,
    output logic [7:0]               drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              valid_r;
    logic [CNT_W-1:0]  cand_r;
    logic [CNT_W-1:0]  prime_r;
    logic [7:0]        drop_r;
    logic              push_req_s;
    logic              pop_s;
    logic              accept_s;
    logic              drop_s;

    // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        push_req_s  = bus.in_valid & bus.in_prime;
        pop_s       = valid_r & bus.out_ready;
        accept_s    = push_req_s & ((level_r < LVL_W'(DEPTH)) | pop_s);
        drop_s      = push_req_s & ~accept_s;
        level_nxt_s = level_r;
        if (accept_s && !pop_s) begin
            level_nxt_s = level_r + LVL_W'(1);
        end else if (pop_s && !accept_s) begin
            level_nxt_s = level_r - LVL_W'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Storage, pointers, occupancy and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            valid_r  <= 1'b0;
            cand_r   <= '0;
            prime_r  <= '0;
            drop_r   <= 8'd0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= bus.in_number;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != LVL_W'(0));
            if (bus.in_valid && (cand_r != {CNT_W{1'b1}})) begin
                cand_r <= cand_r + CNT_W'(1);
            end
            if (push_req_s && (prime_r != {CNT_W{1'b1}})) begin
                prime_r <= prime_r + CNT_W'(1);
            end
            if (drop_s && (drop_r != 8'd255)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    assign bus.out_valid  = valid_r;
    assign bus.out_number = mem_r[rd_ptr_r];
    assign fifo_level     = level_r;
    assign cand_count     = cand_r;
    assign prime_count    = prime_r;
    assign drop_count     = drop_r;
endmodule

// File: tb/tb_prime_collector.sv
// Self-checking bench for prime_collector: table-driven stream plus scoreboarded
// corner-case sequences and a narrow-counter saturation instance.
module tb_prime_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prime_collector_if #(.DATA_W(8)) bus ();
    prime_collector_if #(.DATA_W(8)) bus2 ();

    logic [3:0]  fifo_level, sat_level;
    logic [15:0] cand_count, prime_count;
    logic [3:0]  sat_cand, sat_prime;
    logic [7:0]  drop_count, sat_drop;

    prime_collector #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .fifo_level(fifo_level),
        .cand_count(cand_count), .prime_count(prime_count), .drop_count(drop_count)
    );

    prime_collector #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .bus(bus2), .fifo_level(sat_level),
        .cand_count(sat_cand), .prime_count(sat_prime), .drop_count(sat_drop)
    );

    typedef struct {
        logic       v;
        logic [7:0] n;
        logic       p;
        logic       r;
        logic       exp_valid;
        logic [7:0] exp_num;
    } vec_t;

    vec_t     tbl [21];
    int       total = 0;
    int       bad = 0;
    int       m_level = 0, m_cand = 0, m_prime = 0, m_drop = 0;
    int       sb_q [$];
    int       plist [20] = '{2,3,5,7,11,13,17,19,23,29,31,37,41,43,47,53,59,61,67,71};

    function automatic logic is_prime(input int x);
        if (x < 2) return 1'b0;
        for (int d = 2; d * d <= x; d++) if (x % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle on the main DUT with model update and scoreboard pop check.
    task automatic drive(input logic v, input logic [7:0] n, input logic p, input logic r);
        int  pre;
        logic pop_m, push_m;
        bus.in_valid = v; bus.in_number = n; bus.in_prime = p; bus.out_ready = r;
        pre    = m_level;
        pop_m  = (pre != 0) && r;
        push_m = v && p;
        if (push_m && ((pre < 8) || pop_m)) sb_q.push_back(int'(n));
        else if (push_m && m_drop < 255) m_drop++;
        if (push_m && ((pre < 8) || pop_m)) m_level = pop_m ? pre : pre + 1;
        else m_level = pop_m ? pre - 1 : pre;
        if (v && m_cand < 65535) m_cand++;
        if (push_m && m_prime < 65535) m_prime++;
        @(negedge clk);
        chk("level", int'(fifo_level), pre);
        chk("out_valid", int'(bus.out_valid), int'(pre != 0));
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) chk("pop_on_empty_model", 1, 0);
            else chk("pop_data", int'(bus.out_number), sb_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_cand"}, int'(cand_count), m_cand);
        chk({tag, "_prime"}, int'(prime_count), m_prime);
        chk({tag, "_drop"}, int'(drop_count), m_drop);
        chk({tag, "_level"}, int'(fifo_level), m_level);
    endtask

    task automatic model_clear();
        m_level = 0; m_cand = 0; m_prime = 0; m_drop = 0;
        sb_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_num"}, int'(bus.out_number), 0);
        check_stats(tag);
    endtask

    initial begin
        for (int i = 0; i < 21; i++) begin
            tbl[i].v = 1'b1; tbl[i].n = 8'(i); tbl[i].p = is_prime(i); tbl[i].r = 1'b1;
            tbl[i].exp_valid = is_prime(i); tbl[i].exp_num = 8'(i);
        end
        bus.in_valid = 1'b0; bus.in_number = 8'd0; bus.in_prime = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_number = 8'd0; bus2.in_prime = 1'b0; bus2.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_zero("reset");

        // Stream 0..20 with the reader always ready.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].n, tbl[i].p, tbl[i].r);
            chk("tbl_valid", int'(bus.out_valid), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk("tbl_num", int'(bus.out_number), int'(tbl[i].exp_num));
        end
        chk("s1_cand", int'(cand_count), 21);
        chk("s1_prime", int'(prime_count), 8);
        chk("s1_drop", int'(drop_count), 0);
        chk("s1_level", int'(fifo_level), 0);

        // Overflow: ten primes with the reader stalled, then drain.
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(plist[i]), 1'b1, 1'b0);
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_drop", int'(drop_count), 2);
        for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 1'b0, 1'b1);
        chk("ovf_drained_valid", int'(bus.out_valid), 0);
        check_stats("ovf");

        // Full FIFO with a simultaneous push and pop.
        for (int i = 10; i < 18; i++) drive(1'b1, 8'(plist[i]), 1'b1, 1'b0);
        chk("full_level", int'(fifo_level), 8);
        drive(1'b1, 8'd73, 1'b1, 1'b1);
        chk("fullpp_level", int'(fifo_level), 8);
        chk("fullpp_drop", int'(drop_count), 2);
        for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 1'b0, 1'b1);
        check_stats("fullpp");

        // Pointer wrap with random back-pressure, level held within 1..7.
        for (int i = 0; i < 20; i++) begin
            logic r;
            if (m_level >= 7) r = 1'b1;
            else if (m_level <= 1) r = 1'b0;
            else r = 1'($urandom_range(0, 1));
            drive(1'b1, 8'(plist[i]), 1'b1, r);
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 1'b0, 1'b1);
        chk("wrap_q_empty", sb_q.size(), 0);
        check_stats("wrap");

        // Reset mid-operation with live inputs.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(plist[i]), 1'b1, 1'b0);
        chk("pre_rst_level", int'(fifo_level), 5);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_number = 8'd7; bus.in_prime = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_zero("midrst");
        drive(1'b1, 8'd251, 1'b1, 1'b0);
        chk("post_rst_head", int'(bus.out_number), 251);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        check_stats("post_rst");

        // Saturation on the 4-bit counter instance.
        for (int i = 0; i < 20; i++) begin
            bus2.in_valid = 1'b1; bus2.in_number = 8'(plist[i]); bus2.in_prime = 1'b1; bus2.out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (i == 15) begin
                chk("sat16_prime", int'(sat_prime), 15);
                chk("sat16_cand", int'(sat_cand), 15);
            end
        end
        bus2.in_valid = 1'b0; bus2.in_prime = 1'b0;
        chk("sat_prime", int'(sat_prime), 15);
        chk("sat_cand", int'(sat_cand), 15);
        chk("sat_drop", int'(sat_drop), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prime_collector.md
Name: prime_collector

Overview:
- Downstream consumer of the registered prime checker.
- Takes the checker's per-cycle result stream (number plus prime flag plus valid) and buffers only the prime numbers in a small FIFO.
- Presents the buffered primes to a downstream reader through a valid/ready handshake.
- Keeps saturating statistics: candidates seen, primes found, primes dropped on overflow.

Parameters:
- DATA_W, 8, width of the number field; matches the checker's 8-bit input.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the candidate and prime counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  candidate/result pair valid this cycle
- in_number  input  DATA_W  candidate the in_prime flag refers to; the producer delays the number to align with the checker's one-cycle latency
- in_prime  input  1  checker result for in_number
- out_valid  output  1  FIFO head holds a prime
- out_ready  input  1  downstream accepts the head this cycle
- out_number  output  DATA_W  prime at the FIFO head
- fifo_level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- cand_count  output  CNT_W  number of in_valid cycles, saturating
- prime_count  output  CNT_W  number of in_valid and in_prime cycles, saturating
- drop_count  output  8  primes discarded because the FIFO was full, saturating at 255

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values (rst sampled high at an edge):
  - out_valid = 0, out_number = 0, fifo_level = 0.
  - cand_count = 0, prime_count = 0, drop_count = 0.
  - Read and write pointers = 0.
  - Reset mid-operation discards all buffered entries and statistics with no partial pop. rst has priority over every other input.
- Push request: in_valid and in_prime.
- Pop: out_valid and out_ready.
- FIFO:
  - Show-ahead with registered occupancy. out_valid = (fifo_level != 0).
  - out_number = entry at the read pointer. It is 0 only after reset; it holds stale data when empty, and the bench must not check it while out_valid is 0.
  - No bypass: a prime pushed into an empty FIFO appears on out_valid/out_number the cycle after the push edge, so input-to-output latency is 1 cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. fifo_level tracks occupancy separately.
- Accept rule: a push is accepted when fifo_level < DEPTH, or when fifo_level == DEPTH and a pop occurs in the same cycle. Full with simultaneous pop therefore does not drop.
- Level update:
  - Push accepted and pop: level unchanged, both pointers advance.
  - Push only: +1.
  - Pop only: -1.
- Drop: a push that is not accepted increments drop_count (saturating at 255). Data is discarded and FIFO contents are untouched.
- Ignored inputs:
  - out_ready while empty has no effect.
  - in_valid with in_prime = 0 only increments cand_count.
  - in_prime with in_valid = 0 is ignored entirely.
- Counters:
  - cand_count increments on in_valid.
  - prime_count increments on every push request, whether accepted or dropped.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Invariant: prime_count = (primes popped) + fifo_level + drop_count, as long as no counter has saturated.
- in_number is treated as unsigned DATA_W bits. The block performs no primality check of its own and trusts in_prime.

Test Plan:
- Reset then stream 0..20 with in_valid = 1 and a correct in_prime, out_ready = 1 -> out_number pops 2,3,5,7,11,13,17,19 in order, each 1 cycle after its input; cand_count = 21, prime_count = 8, drop_count = 0, fifo_level returns to 0.
- out_ready = 0 and 10 consecutive primes (2..29) -> fifo_level saturates at 8; drop_count = 2 (23 and 29 dropped); then out_ready = 1 -> pops 2..19 in order, level goes 8->0, out_valid falls after the eighth pop.
- FIFO full and a push coinciding with a pop -> level stays 8, drop_count unchanged, the new prime appears after the 7 older entries.
- Pointer wrap: 20 push/pop cycles with random out_ready and level between 1 and 7 -> output order matches input prime order exactly across the wraps.
- Assert rst for 1 cycle while fifo_level = 5 and counters are nonzero -> next cycle all outputs are 0 and out_valid = 0; a subsequent prime 251 pops as the first entry.
- Saturation with CNT_W = 4: 20 primes with out_ready = 1 -> prime_count = cand_count = 15 and holds there.
